// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream TCDM writer: FSM states and latched transfer configuration.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tcdm_writer_state_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] stride;
        logic [31:0] n_words;
    } tcdm_writer_ctrl_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready data stream with per-byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_intf_tcdm.sv
// Single-port TCDM request/grant channel with read response.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_writer_addrgen.sv
// Holds the latched stride/length, the next write address and the accepted/granted word counters.
module hwpe_stream_tcdm_writer_addrgen
    import hwpe_stream_package::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_clear,
    input  logic              i_start,
    input  tcdm_writer_ctrl_t i_cfg,
    input  logic              i_accept,
    input  logic              i_grant,
    output logic [31:0]       o_next_addr,
    output logic              o_all_accepted,
    output logic              o_all_granted
);

    logic [31:0]          r_stride;
    logic [31:0]          r_n_words;
    logic [31:0]          r_addr;
    logic [CNT_WIDTH-1:0] r_acc_cnt;
    logic [CNT_WIDTH-1:0] r_gnt_cnt;
    logic [CNT_WIDTH-1:0] w_gnt_cnt_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stride  <= '0;
            r_n_words <= '0;
            r_addr    <= '0;
            r_acc_cnt <= '0;
            r_gnt_cnt <= '0;
        end else if (i_clear) begin
            r_addr    <= '0;
            r_acc_cnt <= '0;
            r_gnt_cnt <= '0;
        end else if (i_start) begin
            r_stride  <= i_cfg.stride;
            r_n_words <= i_cfg.n_words;
            r_addr    <= i_cfg.base;
            r_acc_cnt <= '0;
            r_gnt_cnt <= '0;
        end else begin
            if (i_accept) begin
                r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
                r_addr    <= r_addr + r_stride;
            end
            r_gnt_cnt <= w_gnt_cnt_nxt;
        end
    end

    // Includes this cycle's grant so DONE follows the last grant without a bubble.
    assign w_gnt_cnt_nxt  = r_gnt_cnt + CNT_WIDTH'(i_grant);
    assign o_next_addr    = r_addr;
    assign o_all_accepted = (32'(r_acc_cnt) == r_n_words);
    assign o_all_granted  = (32'(w_gnt_cnt_nxt) == r_n_words);

endmodule

// File: rtl/hwpe_stream_tcdm_writer.sv
// Store stage: turns a configured number of stream beats into strided TCDM writes
// through a one-entry request buffer, pulsing done_o after the last grant.
module hwpe_stream_tcdm_writer
    import hwpe_stream_package::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [31:0]          base_addr_i,
    input  logic [31:0]          stride_i,
    input  logic [CNT_WIDTH-1:0] n_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    hwpe_stream_intf_stream.sink push,
    hwpe_stream_intf_tcdm.master tcdm
);

    tcdm_writer_state_t r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_buf_valid;
    logic [31:0]        r_buf_addr;
    logic [31:0]        r_buf_data;
    logic [3:0]         r_buf_strb;

    tcdm_writer_ctrl_t  w_cfg;
    logic               w_start;
    logic               w_ready;
    logic               w_accept;
    logic               w_grant;
    logic [31:0]        w_next_addr;
    logic               w_all_accepted;
    logic               w_all_granted;
    logic               w_unused_rsp;

    assign w_cfg.base    = base_addr_i;
    assign w_cfg.stride  = stride_i;
    assign w_cfg.n_words = 32'(n_words_i);

    assign w_start  = start_i & (r_state == IDLE);
    assign w_grant  = r_buf_valid & tcdm.gnt;
    // The buffer may be refilled in the same cycle its current entry is granted.
    assign w_ready  = (r_state == RUN) & ~w_all_accepted & (~r_buf_valid | tcdm.gnt);
    assign w_accept = push.valid & w_ready;

    hwpe_stream_tcdm_writer_addrgen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) i_addrgen (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_clear        (clear_i),
        .i_start        (w_start),
        .i_cfg          (w_cfg),
        .i_accept       (w_accept),
        .i_grant        (w_grant),
        .o_next_addr    (w_next_addr),
        .o_all_accepted (w_all_accepted),
        .o_all_granted  (w_all_granted)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_all_granted) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_buf_strb  <= '0;
        end else if (clear_i) begin
            r_buf_valid <= 1'b0;
        end else if (w_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= w_next_addr;
            r_buf_data  <= push.data;
            r_buf_strb  <= push.strb;
        end else if (w_grant) begin
            r_buf_valid <= 1'b0;
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign push.ready = w_ready;
    assign tcdm.req   = r_buf_valid;
    assign tcdm.add   = r_buf_addr;
    assign tcdm.data  = r_buf_data;
    assign tcdm.be    = r_buf_strb;
    assign tcdm.wen   = 1'b0;

    // Write-only port: the read response is not used.
    assign w_unused_rsp = ^{tcdm.r_data, tcdm.r_valid};

endmodule
